// File: rtl/ex_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// ex_wb_arbiter_if
//
// Purpose:
//   Bundles every bus signal of the execute -> writeback arbiter: one
//   valid/ready handshake with destination register and result data for
//   each of the ALU, LSU and CSR requesters, the single register-file
//   write port, and the pending-destination scoreboard vector.
//
// Signals:
//   alu_valid/lsu_valid/csr_valid  requester has a result to write back
//   alu_ready/lsu_ready/csr_ready  arbiter can accept that requester's result
//   alu_rd/lsu_rd/csr_rd           destination register (5 bits)
//   alu_data/lsu_data/csr_data     result data (`MAX_BIT_POS+1 bits)
//   wb_en, wb_rd, wb_data          registered register-file write port
//   pending_rd                     bit n set while a buffered entry targets xn
//
// Modports:
//   master  execute-side units (drive valid/rd/data, observe the rest)
//   slave   the arbiter itself
//
// `MAX_BIT_POS defaults to 31 (32-bit data) when not defined by the build.
// ---------------------------------------------------------------------------
`ifndef MAX_BIT_POS
`define MAX_BIT_POS 31
`endif

interface ex_wb_arbiter_if;

  // ALU requester
  logic                  alu_valid;
  logic                  alu_ready;
  logic [4:0]            alu_rd;
  logic [`MAX_BIT_POS:0] alu_data;

  // LSU requester
  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [4:0]            lsu_rd;
  logic [`MAX_BIT_POS:0] lsu_data;

  // CSR requester
  logic                  csr_valid;
  logic                  csr_ready;
  logic [4:0]            csr_rd;
  logic [`MAX_BIT_POS:0] csr_data;

  // Register-file write port and hazard scoreboard
  logic                  wb_en;
  logic [4:0]            wb_rd;
  logic [`MAX_BIT_POS:0] wb_data;
  logic [31:0]           pending_rd;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output csr_valid, csr_rd, csr_data,
    input  alu_ready, lsu_ready, csr_ready,
    input  wb_en, wb_rd, wb_data, pending_rd
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  csr_valid, csr_rd, csr_data,
    output alu_ready, lsu_ready, csr_ready,
    output wb_en, wb_rd, wb_data, pending_rd
  );

endinterface

// File: rtl/ex_wb_arbiter.sv
// ---------------------------------------------------------------------------
// ex_wb_arbiter
//
// Purpose:
//   Merges results from three execution units (ALU, LSU, CSR) onto the single
//   register-file write port. Each unit has a one-entry input buffer; every
//   cycle at most one non-empty buffer is granted and its entry is written
//   back through registered wb_en/wb_rd/wb_data one clock later. A granted
//   buffer can be refilled in the same cycle, so a favoured unit can sustain
//   one result per clock. Writes to x0 are consumed but never enabled.
//
// Ports:
//   clk   sole clock, all state changes on its rising edge
//   rst   synchronous active-high reset
//   bus   ex_wb_arbiter_if.slave: handshakes, write port and pending_rd
//
// Configuration:
//   WB_ARB_ROUND_ROBIN_EN  when defined, round-robin arbitration searching
//                          ALU -> LSU -> CSR starting after the last granted
//                          requester; when undefined, fixed priority
//                          LSU > CSR > ALU and no pointer register exists.
//   MAX_BIT_POS            data MSB index, defaults to 31.
// ---------------------------------------------------------------------------
`ifndef MAX_BIT_POS
`define MAX_BIT_POS 31
`endif

module ex_wb_arbiter (
  input logic           clk,
  input logic           rst,
  ex_wb_arbiter_if.slave bus
);

  localparam int DW   = `MAX_BIT_POS + 1;
  localparam int NREQ = 3;

  // Requester index; also the bit position of each requester in the
  // packed valid/ready/grant vectors below.
  typedef enum logic [1:0] {
    REQ_ALU = 2'd0,
    REQ_LSU = 2'd1,
    REQ_CSR = 2'd2
  } req_e;

  // -------------------------------------------------------------------------
  // Flatten the interface into small arrays so the buffer logic can be
  // written once and looped over the three requesters.
  // -------------------------------------------------------------------------
  logic [NREQ-1:0] in_valid;
  logic [4:0]      in_rd   [NREQ];
  logic [DW-1:0]   in_data [NREQ];

  assign in_valid = {bus.csr_valid, bus.lsu_valid, bus.alu_valid};

  assign in_rd[REQ_ALU]   = bus.alu_rd;
  assign in_rd[REQ_LSU]   = bus.lsu_rd;
  assign in_rd[REQ_CSR]   = bus.csr_rd;

  assign in_data[REQ_ALU] = bus.alu_data;
  assign in_data[REQ_LSU] = bus.lsu_data;
  assign in_data[REQ_CSR] = bus.csr_data;

  // One-entry input buffers
  logic [NREQ-1:0] buf_valid;
  logic [4:0]      buf_rd   [NREQ];
  logic [DW-1:0]   buf_data [NREQ];

  // Arbitration results
  logic [NREQ-1:0] grant;
  logic            grant_any;
  req_e            grant_idx;
  logic [4:0]      sel_rd;
  logic [DW-1:0]   sel_data;

  // Handshake signals
  logic [NREQ-1:0] ready;
  logic [NREQ-1:0] take;

  // Registered write port
  logic            wb_en_q;
  logic [4:0]      wb_rd_q;
  logic [DW-1:0]   wb_data_q;

  // Scoreboard vector
  logic [31:0]     pending;

  // Returns a one-hot grant for the first set bit of v when searched in the
  // order first, second, third; all zero if v is empty.
  function automatic logic [NREQ-1:0] first_set(
    input logic [NREQ-1:0] v,
    input req_e            first,
    input req_e            second,
    input req_e            third
  );
    logic [NREQ-1:0] g;
    g = '0;
    if (v[first]) begin
      g[first] = 1'b1;
    end else if (v[second]) begin
      g[second] = 1'b1;
    end else if (v[third]) begin
      g[third] = 1'b1;
    end
    return g;
  endfunction

`ifdef WB_ARB_ROUND_ROBIN_EN
  // -------------------------------------------------------------------------
  // Round-robin arbitration. last_grant remembers who won most recently; the
  // search starts with the requester after it in ALU -> LSU -> CSR order, so
  // the last winner is always considered last. Only registered buffer state
  // feeds the grant, keeping valid inputs off the ready path.
  // -------------------------------------------------------------------------
  req_e last_grant;

  always_comb begin
    grant = '0;
    case (last_grant)
      REQ_ALU: grant = first_set(buf_valid, REQ_LSU, REQ_CSR, REQ_ALU);
      REQ_LSU: grant = first_set(buf_valid, REQ_CSR, REQ_ALU, REQ_LSU);
      default: grant = first_set(buf_valid, REQ_ALU, REQ_LSU, REQ_CSR);
    endcase
  end

  // The pointer only moves when somebody actually wins, so an idle period
  // does not disturb fairness.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= REQ_ALU;
    end else if (grant_any) begin
      last_grant <= grant_idx;
    end
  end
`else
  // -------------------------------------------------------------------------
  // Fixed priority arbitration: LSU first (loads are usually on the critical
  // dependency path), then CSR, then ALU. No pointer state is needed.
  // -------------------------------------------------------------------------
  always_comb begin
    grant = first_set(buf_valid, REQ_LSU, REQ_CSR, REQ_ALU);
  end
`endif

  // -------------------------------------------------------------------------
  // Encode the one-hot grant and pick the winning entry. grant_idx defaults
  // to ALU when nothing is granted; the payload is then ignored because
  // grant_any is low.
  // -------------------------------------------------------------------------
  always_comb begin
    grant_any = |grant;
    grant_idx = REQ_ALU;
    if (grant[REQ_LSU]) begin
      grant_idx = REQ_LSU;
    end else if (grant[REQ_CSR]) begin
      grant_idx = REQ_CSR;
    end
  end

  always_comb begin
    sel_rd   = buf_rd[REQ_ALU];
    sel_data = buf_data[REQ_ALU];
    case (grant_idx)
      REQ_LSU: begin
        sel_rd   = buf_rd[REQ_LSU];
        sel_data = buf_data[REQ_LSU];
      end
      REQ_CSR: begin
        sel_rd   = buf_rd[REQ_CSR];
        sel_data = buf_data[REQ_CSR];
      end
      default: begin
        sel_rd   = buf_rd[REQ_ALU];
        sel_data = buf_data[REQ_ALU];
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // A requester may hand over a result when its buffer is empty or is being
  // drained this very cycle, which is what allows back-to-back streaming.
  // Ready is forced low during reset so nothing is accepted and then thrown
  // away by the buffer clear.
  // -------------------------------------------------------------------------
  assign ready = {NREQ{~rst}} & (~buf_valid | grant);
  assign take  = in_valid & ready;

  // -------------------------------------------------------------------------
  // Buffer occupancy. Whenever ready is high the buffer is either empty or
  // being granted, so its next occupancy is simply whether a new entry
  // arrives; otherwise it keeps its (still ungranted) entry.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (ready[i]) begin
          buf_valid[i] <= in_valid[i];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Buffer payload. Only meaningful while the matching buf_valid bit is set,
  // so it needs no reset; it loads on every completed handshake.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (take[i]) begin
        buf_rd[i]   <= in_rd[i];
        buf_data[i] <= in_data[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Register-file write port. The granted entry is registered one clock
  // after its grant; wb_en pulses for that single cycle unless the target is
  // x0. With no grant wb_en drops back to 0 while rd/data hold their value.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      wb_en_q <= grant_any && (sel_rd != 5'd0);
      if (grant_any) begin
        wb_rd_q   <= sel_rd;
        wb_data_q <= sel_data;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Hazard scoreboard: one bit per architectural register that still has a
  // result waiting in a buffer. x0 is never a real destination, so bit 0 is
  // never set even if an x0 entry is buffered.
  // -------------------------------------------------------------------------
  always_comb begin
    pending = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (buf_valid[i] && (buf_rd[i] != 5'd0)) begin
        pending[buf_rd[i]] = 1'b1;
      end
    end
  end

  // Drive the interface outputs
  assign bus.alu_ready  = ready[REQ_ALU];
  assign bus.lsu_ready  = ready[REQ_LSU];
  assign bus.csr_ready  = ready[REQ_CSR];
  assign bus.wb_en      = wb_en_q;
  assign bus.wb_rd      = wb_rd_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.pending_rd = pending;

endmodule

// File: tb/tb_ex_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ex_wb_arbiter
//
// Purpose:
//   Drives ex_wb_arbiter through directed scenarios (reset, single ALU write
//   latency, three-way contention ordering, sustained load fairness, x0
//   streaming, scoreboard bit, reset with full buffers) followed by random
//   traffic. A transaction-level model of three one-entry buffers plus an
//   arbitration rule predicts ready, pending_rd and the write port.
//   Honours WB_ARB_ROUND_ROBIN_EN in the same way as the design.
// ---------------------------------------------------------------------------
`ifndef MAX_BIT_POS
`define MAX_BIT_POS 31
`endif

module tb_ex_wb_arbiter;

  localparam int DW = `MAX_BIT_POS + 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ex_wb_arbiter_if bus();

  ex_wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: index 0 = ALU, 1 = LSU, 2 = CSR
  bit            m_valid [3];
  logic [4:0]    m_rd    [3];
  logic [DW-1:0] m_data  [3];
  bit            m_init = 1'b0;
`ifdef WB_ARB_ROUND_ROBIN_EN
  int            m_last = 0;
`endif
  logic          exp_en;
  logic [4:0]    exp_rd;
  logic [DW-1:0] exp_data;

  // Stimulus currently applied
  bit            s_valid [3];
  logic [DW-1:0] s_data  [3];
  logic [4:0]    s_rd    [3];

  string names [3] = '{"alu", "lsu", "csr"};

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Which requester wins this cycle according to the arbitration rule, or -1.
  function automatic int modelGrant();
`ifdef WB_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (m_last + k) % 3;
      if (m_valid[i]) return i;
    end
    return -1;
`else
    int order [3] = '{1, 2, 0};
    for (int k = 0; k < 3; k++) begin
      if (m_valid[order[k]]) return order[k];
    end
    return -1;
`endif
  endfunction

  function automatic logic getReady(input int i);
    case (i)
      0:       return bus.alu_ready;
      1:       return bus.lsu_ready;
      default: return bus.csr_ready;
    endcase
  endfunction

  task automatic applyStimulus(input bit [2:0] v,
                               input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                               input logic [DW-1:0] d2, input bit r);
    s_valid[0] = v[0]; s_valid[1] = v[1]; s_valid[2] = v[2];
    s_rd[0] = r0; s_rd[1] = r1; s_rd[2] = r2;
    s_data[0] = d0; s_data[1] = d1; s_data[2] = d2;
    bus.alu_valid = v[0]; bus.alu_rd = r0; bus.alu_data = d0;
    bus.lsu_valid = v[1]; bus.lsu_rd = r1; bus.lsu_data = d1;
    bus.csr_valid = v[2]; bus.csr_rd = r2; bus.csr_data = d2;
    rst = r;
  endtask

  // One clock: check pre-edge outputs, advance the model across the edge,
  // check the write port, and return at the following falling edge.
  task automatic runCycle();
    int          g;
    bit          hs [3];
    bit          was_rst;
    logic        exp_ready;
    logic [31:0] exp_pend;
    #1;
    was_rst = rst;
    g = modelGrant();
    for (int i = 0; i < 3; i++) begin
      exp_ready = !was_rst && (!m_valid[i] || g == i);
      hs[i] = s_valid[i] && exp_ready;
      if (m_init || was_rst)
        checkOutput($sformatf("%s_ready", names[i]), 64'(getReady(i)), 64'(exp_ready));
    end
    if (m_init) begin
      exp_pend = '0;
      for (int i = 0; i < 3; i++)
        if (m_valid[i] && m_rd[i] != 5'd0) exp_pend[m_rd[i]] = 1'b1;
      checkOutput("pending_rd", 64'(bus.pending_rd), 64'(exp_pend));
    end
    @(posedge clk);
    if (was_rst) begin
      for (int i = 0; i < 3; i++) m_valid[i] = 1'b0;
`ifdef WB_ARB_ROUND_ROBIN_EN
      m_last = 0;
`endif
      exp_en = 1'b0; exp_rd = '0; exp_data = '0;
      m_init = 1'b1;
    end else if (m_init) begin
      exp_en = 1'b0;
      if (g >= 0) begin
        exp_en   = (m_rd[g] != 5'd0);
        exp_rd   = m_rd[g];
        exp_data = m_data[g];
        m_valid[g] = 1'b0;
`ifdef WB_ARB_ROUND_ROBIN_EN
        m_last = g;
`endif
      end
      for (int i = 0; i < 3; i++) begin
        if (hs[i]) begin
          m_valid[i] = 1'b1;
          m_rd[i]    = s_rd[i];
          m_data[i]  = s_data[i];
        end
      end
    end
    #1;
    if (m_init) begin
      checkOutput("wb_en", 64'(bus.wb_en), 64'(exp_en));
      if (exp_en || was_rst) begin
        checkOutput("wb_rd", 64'(bus.wb_rd), 64'(exp_rd));
        checkOutput("wb_data", 64'(bus.wb_data), 64'(exp_data));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int cnt [3];
    bit [2:0]      rv;
    logic [4:0]    rr [3];
    logic [DW-1:0] rd_data [3];
    bit            rrst;

    applyStimulus(3'b000, '0, '0, '0, '0, '0, '0, 1'b1);
    @(negedge clk);

    // Reset
    runCycle();
    runCycle();
    checkOutput("reset_wb_en", 64'(bus.wb_en), 64'd0);
    checkOutput("reset_wb_rd", 64'(bus.wb_rd), 64'd0);
    checkOutput("reset_wb_data", 64'(bus.wb_data), 64'd0);
    checkOutput("reset_pending", 64'(bus.pending_rd), 64'd0);
    checkOutput("reset_alu_ready", 64'(bus.alu_ready), 64'd0);

    // Single ALU write, handshake in the first cycle after reset
    applyStimulus(3'b001, 5'd5, '0, '0, DW'(32'h12345678), '0, '0, 1'b0);
    runCycle();
    checkOutput("lat_wb_en_early", 64'(bus.wb_en), 64'd0);
    applyStimulus(3'b000, '0, '0, '0, '0, '0, '0, 1'b0);
    runCycle();
    checkOutput("lat_wb_en", 64'(bus.wb_en), 64'd1);
    checkOutput("lat_wb_rd", 64'(bus.wb_rd), 64'd5);
    checkOutput("lat_wb_data", 64'(bus.wb_data), 64'h12345678);
    runCycle();
    checkOutput("lat_wb_en_pulse", 64'(bus.wb_en), 64'd0);

    // All three at once: LSU(2), CSR(3), ALU(1) in both arbitration modes
    applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, DW'(32'hA1), DW'(32'hB2), DW'(32'hC3), 1'b0);
    runCycle();
    applyStimulus(3'b000, '0, '0, '0, '0, '0, '0, 1'b0);
    runCycle();
    checkOutput("order1_en", 64'(bus.wb_en), 64'd1);
    checkOutput("order1_rd", 64'(bus.wb_rd), 64'd2);
    runCycle();
    checkOutput("order2_en", 64'(bus.wb_en), 64'd1);
    checkOutput("order2_rd", 64'(bus.wb_rd), 64'd3);
    runCycle();
    checkOutput("order3_en", 64'(bus.wb_en), 64'd1);
    checkOutput("order3_rd", 64'(bus.wb_rd), 64'd1);
    runCycle();
    checkOutput("order_idle_en", 64'(bus.wb_en), 64'd0);

    // Sustained three-port load: count writes per requester over 9 cycles
    for (int k = 0; k < 3; k++) cnt[k] = 0;
    applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, DW'(32'h11), DW'(32'h22), DW'(32'h33), 1'b0);
    for (int n = 0; n < 10; n++) begin
      runCycle();
      if (n >= 1 && bus.wb_en === 1'b1 && bus.wb_rd >= 5'd1 && bus.wb_rd <= 5'd3)
        cnt[int'(bus.wb_rd) - 1]++;
    end
`ifdef WB_ARB_ROUND_ROBIN_EN
    checkOutput("rr_alu_share", 64'(cnt[0]), 64'd3);
    checkOutput("rr_lsu_share", 64'(cnt[1]), 64'd3);
    checkOutput("rr_csr_share", 64'(cnt[2]), 64'd3);
`else
    checkOutput("fixed_alu_share", 64'(cnt[0]), 64'd0);
    checkOutput("fixed_lsu_share", 64'(cnt[1]), 64'd9);
    checkOutput("fixed_csr_share", 64'(cnt[2]), 64'd0);
`endif
    applyStimulus(3'b000, '0, '0, '0, '0, '0, '0, 1'b0);
    for (int n = 0; n < 4; n++) runCycle();

    // ALU streaming writes to x0: always ready, never enabled
    for (int n = 0; n < 8; n++) begin
      applyStimulus(3'b001, 5'd0, '0, '0, DW'($urandom), '0, '0, 1'b0);
      runCycle();
      checkOutput("x0_alu_ready", 64'(bus.alu_ready), 64'd1);
      checkOutput("x0_wb_en", 64'(bus.wb_en), 64'd0);
    end
    applyStimulus(3'b000, '0, '0, '0, '0, '0, '0, 1'b0);
    runCycle();
    runCycle();

    // Scoreboard bit for an LSU entry targeting x7
    applyStimulus(3'b010, '0, 5'd7, '0, '0, DW'(32'h77), '0, 1'b0);
    runCycle();
    checkOutput("pend_x7_set", 64'(bus.pending_rd), 64'h80);
    applyStimulus(3'b000, '0, '0, '0, '0, '0, '0, 1'b0);
    runCycle();
    checkOutput("pend_x7_clear", 64'(bus.pending_rd), 64'd0);
    checkOutput("pend_x7_wb_rd", 64'(bus.wb_rd), 64'd7);

    // Reset with all buffers full
    applyStimulus(3'b111, 5'd4, 5'd5, 5'd6, DW'(32'h4), DW'(32'h5), DW'(32'h6), 1'b0);
    runCycle();
    applyStimulus(3'b000, '0, '0, '0, '0, '0, '0, 1'b1);
    runCycle();
    checkOutput("rstfull_wb_en", 64'(bus.wb_en), 64'd0);
    checkOutput("rstfull_pending", 64'(bus.pending_rd), 64'd0);
    checkOutput("rstfull_lsu_ready", 64'(bus.lsu_ready), 64'd0);
    applyStimulus(3'b000, '0, '0, '0, '0, '0, '0, 1'b0);
    runCycle();
    checkOutput("rstfull_wb_en_after", 64'(bus.wb_en), 64'd0);
    checkOutput("rstfull_alu_ready_back", 64'(bus.alu_ready), 64'd1);
    checkOutput("rstfull_lsu_ready_back", 64'(bus.lsu_ready), 64'd1);
    checkOutput("rstfull_csr_ready_back", 64'(bus.csr_ready), 64'd1);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        rv[i] = ($urandom_range(0, 9) < 6);
        rr[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        rd_data[i] = DW'($urandom);
      end
      rrst = ($urandom_range(0, 49) == 0);
      applyStimulus(rv, rr[0], rr[1], rr[2], rd_data[0], rd_data[1], rd_data[2], rrst);
      runCycle();
    end

    applyStimulus(3'b000, '0, '0, '0, '0, '0, '0, 1'b0);
    runCycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
